// File: rtl/calc_pkg.sv
// calc_pkg: shared widths, opcode map, key/state enums and operand-range
// helpers for the calculator command sequencer.
package calc_pkg;

    localparam int unsigned OPCODE_LENGTH = 5;
    localparam int unsigned NUM_LENGTH    = 9;
    localparam int unsigned RESULT_WIDTH  = 32;

    // Signed operand range the ALU accepts (-256..255 for 9 bits)
    localparam int NUM_MAX = (1 << (NUM_LENGTH - 1)) - 1;
    localparam int NUM_MIN = -(NUM_MAX + 1);

    // Binary operations
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD      = 5'b00000;
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB      = 5'b00001;
    localparam logic [OPCODE_LENGTH-1:0] OP_MUL      = 5'b00010;
    localparam logic [OPCODE_LENGTH-1:0] OP_DIV      = 5'b00011;
    localparam logic [OPCODE_LENGTH-1:0] OP_MOD      = 5'b01011;
    // Unary operations
    localparam logic [OPCODE_LENGTH-1:0] OP_SQUARE   = 5'b00100;
    localparam logic [OPCODE_LENGTH-1:0] OP_CUBE     = 5'b00101;
    localparam logic [OPCODE_LENGTH-1:0] OP_SQRT     = 5'b00110;
    localparam logic [OPCODE_LENGTH-1:0] OP_NEG      = 5'b00111;
    localparam logic [OPCODE_LENGTH-1:0] OP_ABS      = 5'b01000;
    localparam logic [OPCODE_LENGTH-1:0] OP_INC      = 5'b01001;
    localparam logic [OPCODE_LENGTH-1:0] OP_DEC      = 5'b01010;
    localparam logic [OPCODE_LENGTH-1:0] OP_FACT     = 5'b01100;
    localparam logic [OPCODE_LENGTH-1:0] OP_RECIP    = 5'b01101;
    localparam logic [OPCODE_LENGTH-1:0] OP_LOG      = 5'b01110;
    localparam logic [OPCODE_LENGTH-1:0] OP_PI       = 5'b01111;
    // Memory operations, handled locally
    localparam logic [OPCODE_LENGTH-1:0] OP_MEM_ADD  = 5'b10001;
    localparam logic [OPCODE_LENGTH-1:0] OP_MEM_SUB  = 5'b10010;
    localparam logic [OPCODE_LENGTH-1:0] OP_MEM_LOAD = 5'b10100;
    localparam logic [OPCODE_LENGTH-1:0] OP_MEM_CLR  = 5'b11000;

    typedef enum logic [1:0] {
        KEY_DIGIT = 2'b00,
        KEY_OP    = 2'b01,
        KEY_EQ    = 2'b10,
        KEY_CLR   = 2'b11
    } key_type_e;

    typedef enum logic [2:0] {
        ENTRY_A = 3'd0,
        ENTRY_B = 3'd1,
        EXEC    = 3'd2,
        RESULT  = 3'd3,
        ERROR   = 3'd4
    } state_e;

    function automatic logic is_digit(input logic [OPCODE_LENGTH-1:0] d);
        return d <= OPCODE_LENGTH'(9);
    endfunction

    function automatic logic is_binary(input logic [OPCODE_LENGTH-1:0] op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD};
    endfunction

    // Unary ops and Pi issue immediately with B = 0
    function automatic logic is_unary(input logic [OPCODE_LENGTH-1:0] op);
        return ((op >= OP_SQUARE) && (op <= OP_DEC)) ||
               ((op >= OP_FACT) && (op <= OP_PI));
    endfunction

    function automatic logic in_num_range(input logic signed [RESULT_WIDTH-1:0] v);
        return (v >= RESULT_WIDTH'(NUM_MIN)) && (v <= RESULT_WIDTH'(NUM_MAX));
    endfunction

endpackage

// File: rtl/dec_entry_accum.sv
// dec_entry_accum: decimal operand accumulator.
// Ports: clk/rst (sync active-high); clr zeroes; load_en/load_val loads a
// value; digit_en/digit appends a decimal digit (restart uses 0 as the base);
// acc is the held operand, acc_nxt_c its combinational next value.
// Priority: clr > load > digit. Digits > 9 or results outside the operand
// range are dropped with acc held.
module dec_entry_accum
    import calc_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          restart,
    input  logic                          digit_en,
    input  logic [OPCODE_LENGTH-1:0]      digit,
    input  logic                          load_en,
    input  logic signed [NUM_LENGTH-1:0]  load_val,
    output logic signed [NUM_LENGTH-1:0]  acc,
    output logic signed [NUM_LENGTH-1:0]  acc_nxt_c
);

    localparam logic signed [RESULT_WIDTH-1:0] TEN = RESULT_WIDTH'(10);

    logic signed [RESULT_WIDTH-1:0] base_w;
    logic signed [RESULT_WIDTH-1:0] cand_w;

    // Candidate value computed wide so overflow is detectable before truncation
    always_comb begin
        base_w    = restart ? '0 : RESULT_WIDTH'(acc);
        cand_w    = (base_w * TEN) + $signed(RESULT_WIDTH'(digit));
        acc_nxt_c = acc;
        if (clr) begin
            acc_nxt_c = '0;
        end else if (load_en) begin
            acc_nxt_c = load_val;
        end else if (digit_en && is_digit(digit) && in_num_range(cand_w)) begin
            acc_nxt_c = NUM_LENGTH'(cand_w);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else begin
            acc <= acc_nxt_c;
        end
    end

endmodule

// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: keypad-side command sequencer for the calculator ALU.
// Accepts key tokens (valid/ready), builds operands A/B, issues registered
// opcode/operand pairs to the ALU, captures the ALU result for display and
// owns the memory register.
// Ports: clk, rst (sync active-high); key_valid/key_ready/key_type/key_data
// token input; alu_opcode/alu_num_a/alu_num_b to the ALU, alu_result back;
// disp_value/disp_valid display; mem_value memory; error sticky flag.
// Build option: define CALC_SEQ_MEMORY_EN to enable the memory register and
// its opcodes; otherwise mem_value is 0 and memory opcodes are ignored.
module calc_op_sequencer
    import calc_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            key_valid,
    output logic                            key_ready,
    input  logic [1:0]                      key_type,
    input  logic [OPCODE_LENGTH-1:0]        key_data,
    output logic [OPCODE_LENGTH-1:0]        alu_opcode,
    output logic signed [NUM_LENGTH-1:0]    alu_num_a,
    output logic signed [NUM_LENGTH-1:0]    alu_num_b,
    input  logic signed [RESULT_WIDTH-1:0]  alu_result,
    output logic signed [RESULT_WIDTH-1:0]  disp_value,
    output logic                            disp_valid,
    output logic signed [RESULT_WIDTH-1:0]  mem_value,
    output logic                            error
);

    state_e    state, state_nxt;
    key_type_e ktype;

    logic tok, is_dig, is_bin, is_un, is_eq, is_clr;
    logic is_madd, is_msub, is_mload, is_mclr;
    logic entry_st, res_fits, mem_fits, div_zero;

    logic signed [RESULT_WIDTH-1:0] mem_q;
    logic signed [NUM_LENGTH-1:0]   a_q, b_q, a_nxt_c, b_nxt_c;
    logic signed [NUM_LENGTH-1:0]   res_num, mem_num, load_val;
    logic a_clr, a_restart, a_digit, a_load;
    logic b_clr, b_digit, b_load;

    logic                           issue;
    logic [OPCODE_LENGTH-1:0]       issue_op, op_latch, op_latch_nxt;
    logic signed [NUM_LENGTH-1:0]   issue_a, issue_b;
    logic signed [RESULT_WIDTH-1:0] disp_nxt;
    logic                           disp_valid_nxt;

    // Token decode
    assign ktype    = key_type_e'(key_type);
    assign tok      = key_valid && key_ready;
    assign is_dig   = tok && (ktype == KEY_DIGIT) && is_digit(key_data);
    assign is_bin   = tok && (ktype == KEY_OP) && is_binary(key_data);
    assign is_un    = tok && (ktype == KEY_OP) && is_unary(key_data);
    assign is_eq    = tok && (ktype == KEY_EQ);
    assign is_clr   = tok && (ktype == KEY_CLR);
    // States in which operand/operator/memory tokens take effect
    assign entry_st = state inside {ENTRY_A, ENTRY_B, RESULT};
    // disp_value holds the last result while in RESULT
    assign res_num  = NUM_LENGTH'(disp_value);
    assign res_fits = in_num_range(disp_value);
    assign mem_num  = NUM_LENGTH'(mem_q);
    assign mem_fits = in_num_range(mem_q);
    assign div_zero = ((op_latch == OP_DIV) || (op_latch == OP_MOD)) && (b_q == '0);

`ifdef CALC_SEQ_MEMORY_EN
    assign is_madd  = tok && (ktype == KEY_OP) && (key_data == OP_MEM_ADD);
    assign is_msub  = tok && (ktype == KEY_OP) && (key_data == OP_MEM_SUB);
    assign is_mload = tok && (ktype == KEY_OP) && (key_data == OP_MEM_LOAD);
    assign is_mclr  = tok && (ktype == KEY_OP) && (key_data == OP_MEM_CLR);

    // Memory register; arithmetic wraps at RESULT_WIDTH
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
        end else if (entry_st) begin
            if (is_madd) begin
                mem_q <= mem_q + disp_value;
            end else if (is_msub) begin
                mem_q <= mem_q - disp_value;
            end else if (is_mclr) begin
                mem_q <= '0;
            end
        end
    end
`else
    assign is_madd  = 1'b0;
    assign is_msub  = 1'b0;
    assign is_mload = 1'b0;
    assign is_mclr  = 1'b0;
    assign mem_q    = '0;
`endif

    assign mem_value = mem_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ENTRY_A;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (state == EXEC) begin
            state_nxt = RESULT;
        end else if (is_clr) begin
            state_nxt = ENTRY_A;
        end else if (entry_st) begin
            if (is_dig && (state == RESULT)) begin
                state_nxt = ENTRY_A;
            end else if (is_bin) begin
                state_nxt = ((state == RESULT) && !res_fits) ? ERROR : ENTRY_B;
            end else if (is_un) begin
                state_nxt = ((state == RESULT) && !res_fits) ? ERROR : EXEC;
            end else if (is_eq && (state == ENTRY_B)) begin
                state_nxt = div_zero ? ERROR : EXEC;
            end else if (is_mload) begin
                if (!mem_fits) begin
                    state_nxt = ERROR;
                end else if (state == RESULT) begin
                    state_nxt = ENTRY_A;
                end
            end
        end
    end

    // Output / datapath control
    always_comb begin
        a_clr          = 1'b0;
        a_restart      = 1'b0;
        a_digit        = 1'b0;
        a_load         = 1'b0;
        b_clr          = 1'b0;
        b_digit        = 1'b0;
        b_load         = 1'b0;
        load_val       = '0;
        issue          = 1'b0;
        issue_op       = key_data;
        issue_a        = a_q;
        issue_b        = '0;
        op_latch_nxt   = op_latch;
        disp_nxt       = disp_value;
        disp_valid_nxt = 1'b0;

        if (state == EXEC) begin
            disp_nxt       = alu_result;
            disp_valid_nxt = 1'b1;
        end else if (is_clr) begin
            a_clr        = 1'b1;
            b_clr        = 1'b1;
            op_latch_nxt = '0;
            disp_nxt     = '0;
        end else if (entry_st) begin
            if (is_dig) begin
                if (state == ENTRY_B) begin
                    b_digit  = 1'b1;
                    disp_nxt = RESULT_WIDTH'(b_nxt_c);
                end else begin
                    a_digit   = 1'b1;
                    a_restart = (state == RESULT);
                    disp_nxt  = RESULT_WIDTH'(a_nxt_c);
                end
            end else if (is_bin) begin
                if ((state != RESULT) || res_fits) begin
                    op_latch_nxt = key_data;
                    b_clr        = 1'b1;
                    if (state == RESULT) begin
                        a_load   = 1'b1;
                        load_val = res_num;
                    end
                end
            end else if (is_un) begin
                if ((state != RESULT) || res_fits) begin
                    issue = 1'b1;
                    if (state == RESULT) begin
                        a_load   = 1'b1;
                        load_val = res_num;
                        issue_a  = res_num;
                    end
                end
            end else if (is_eq && (state == ENTRY_B) && !div_zero) begin
                issue    = 1'b1;
                issue_op = op_latch;
                issue_b  = b_q;
            end else if (is_mload && mem_fits) begin
                load_val = mem_num;
                disp_nxt = mem_q;
                if (state == ENTRY_B) begin
                    b_load = 1'b1;
                end else begin
                    a_load = 1'b1;
                end
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            key_ready  <= 1'b1;
            error      <= 1'b0;
            disp_value <= '0;
            disp_valid <= 1'b0;
            op_latch   <= '0;
            alu_opcode <= '0;
            alu_num_a  <= '0;
            alu_num_b  <= '0;
        end else begin
            key_ready  <= (state_nxt != EXEC);
            error      <= (state_nxt == ERROR);
            disp_value <= disp_nxt;
            disp_valid <= disp_valid_nxt;
            op_latch   <= op_latch_nxt;
            if (issue) begin
                alu_opcode <= issue_op;
                alu_num_a  <= issue_a;
                alu_num_b  <= issue_b;
            end
        end
    end

    dec_entry_accum u_acc_a (
        .clk       (clk),
        .rst       (rst),
        .clr       (a_clr),
        .restart   (a_restart),
        .digit_en  (a_digit),
        .digit     (key_data),
        .load_en   (a_load),
        .load_val  (load_val),
        .acc       (a_q),
        .acc_nxt_c (a_nxt_c)
    );

    dec_entry_accum u_acc_b (
        .clk       (clk),
        .rst       (rst),
        .clr       (b_clr),
        .restart   (1'b0),
        .digit_en  (b_digit),
        .digit     (key_data),
        .load_en   (b_load),
        .load_val  (load_val),
        .acc       (b_q),
        .acc_nxt_c (b_nxt_c)
    );

endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb_calc_op_sequencer: directed self-checking bench for calc_op_sequencer
// with a behavioural ALU and a scoreboard of expected issues/results.
module tb_calc_op_sequencer;
    import calc_pkg::*;

    logic                           clk = 1'b0;
    logic                           rst;
    logic                           key_valid;
    logic                           key_ready;
    logic [1:0]                     key_type;
    logic [OPCODE_LENGTH-1:0]       key_data;
    logic [OPCODE_LENGTH-1:0]       alu_opcode;
    logic signed [NUM_LENGTH-1:0]   alu_num_a;
    logic signed [NUM_LENGTH-1:0]   alu_num_b;
    logic signed [RESULT_WIDTH-1:0] alu_result;
    logic signed [RESULT_WIDTH-1:0] disp_value;
    logic                           disp_valid;
    logic signed [RESULT_WIDTH-1:0] mem_value;
    logic                           error;

    typedef struct {
        logic [OPCODE_LENGTH-1:0] op;
        int                       a;
        int                       b;
        int                       res;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    calc_op_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_type   (key_type),
        .key_data   (key_data),
        .alu_opcode (alu_opcode),
        .alu_num_a  (alu_num_a),
        .alu_num_b  (alu_num_b),
        .alu_result (alu_result),
        .disp_value (disp_value),
        .disp_valid (disp_valid),
        .mem_value  (mem_value),
        .error      (error)
    );

    // Behavioural ALU covering the operations exercised here
    function automatic int alu_model(input logic [OPCODE_LENGTH-1:0] op, input int a, input int b);
        int r;
        case (op)
            5'd0:    r = a + b;
            5'd1:    r = a - b;
            5'd2:    r = a * b;
            5'd3:    r = (b == 0) ? 0 : a / b;
            5'd4:    r = a * a;
            5'd5:    r = a * a * a;
            5'd11:   r = (b == 0) ? 0 : a % b;
            5'd15:   r = 3;
            default: r = 0;
        endcase
        return r;
    endfunction

    always_comb alu_result = alu_model(alu_opcode, int'(alu_num_a), int'(alu_num_b));

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic send_key(input logic [1:0] t, input logic [OPCODE_LENGTH-1:0] d);
        int n = 0;
        while (!key_ready && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (!key_ready) chk("key_ready wait", 32'(key_ready), 1);
        key_type  = t;
        key_data  = d;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic dig(input int d);
        send_key(KEY_DIGIT, OPCODE_LENGTH'(d));
    endtask

    task automatic opk(input logic [OPCODE_LENGTH-1:0] o);
        send_key(KEY_OP, o);
    endtask

    task automatic push_exp(input logic [OPCODE_LENGTH-1:0] op, input int a, input int b, input int res);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.res = res;
        sb.push_back(e);
    endtask

    // Called #1 after the issuing edge: checks operands, then the result pulse
    task automatic check_issue();
        exp_t e;
        int   n;
        if (sb.size() == 0) begin
            chk("scoreboard empty", 32'(sb.size()), 1);
            return;
        end
        e = sb.pop_front();
        chk("alu_opcode", 32'(alu_opcode), 32'(e.op));
        chk("alu_num_a", 32'(alu_num_a), e.a);
        chk("alu_num_b", 32'(alu_num_b), e.b);
        chk("key_ready in exec", 32'(key_ready), 0);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!disp_valid && n < 4);
        chk("disp_valid latency", n, 1);
        chk("disp_value result", disp_value, e.res);
        chk("key_ready after exec", 32'(key_ready), 1);
        @(posedge clk); #1;
        chk("disp_valid width", 32'(disp_valid), 0);
    endtask

    task automatic check_no_pulse(input string tag, input int cycles);
        int cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            if (disp_valid) cnt++;
            @(posedge clk); #1;
        end
        chk(tag, cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_type  = 2'b00;
        key_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset key_ready", 32'(key_ready), 1);
        chk("reset disp_value", disp_value, 0);
        chk("reset disp_valid", 32'(disp_valid), 0);
        chk("reset error", 32'(error), 0);
        chk("reset mem_value", mem_value, 0);
        chk("reset alu_opcode", 32'(alu_opcode), 0);
        chk("reset alu_num_a", 32'(alu_num_a), 0);
        chk("reset alu_num_b", 32'(alu_num_b), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 12 + 34
        dig(1); dig(2);
        chk("entry A display", disp_value, 12);
        opk(OP_ADD);
        dig(3); dig(4);
        chk("entry B display", disp_value, 34);
        push_exp(OP_ADD, 12, 34, 46);
        send_key(KEY_EQ, '0);
        check_issue();

        // Overflow digit dropped
        send_key(KEY_CLR, '0);
        chk("clear display", disp_value, 0);
        dig(2); dig(5); dig(6);
        chk("overflow digit dropped", disp_value, 25);
        chk("overflow no error", 32'(error), 0);

        // Upper boundary 255 accepted, invalid digit ignored
        send_key(KEY_CLR, '0);
        dig(2); dig(5); dig(5);
        chk("boundary 255", disp_value, 255);
        dig(12);
        chk("digit 12 ignored", disp_value, 255);

        // Divide by zero
        send_key(KEY_CLR, '0);
        dig(9); opk(OP_DIV); dig(0);
        send_key(KEY_EQ, '0);
        chk("div0 error", 32'(error), 1);
        chk("div0 no issue opcode", 32'(alu_opcode), 0);
        chk("div0 no issue a", 32'(alu_num_a), 12);
        check_no_pulse("div0 no disp_valid", 3);
        dig(5);
        chk("error ignores digit", disp_value, 0);
        chk("error sticky", 32'(error), 1);
        send_key(KEY_CLR, '0);
        chk("clear error", 32'(error), 0);
        chk("clear after error display", disp_value, 0);

        // Undefined opcode accepted and ignored
        dig(3); opk(5'b10110); dig(4);
        chk("undefined opcode ignored", disp_value, 34);

        // Memory add, clear, recall, then square to expose A
        send_key(KEY_CLR, '0);
        dig(7); opk(OP_MEM_ADD);
        send_key(KEY_CLR, '0);
        opk(OP_MEM_LOAD);
`ifdef CALC_SEQ_MEMORY_EN
        chk("mem_value after add", mem_value, 7);
        chk("mem recall display", disp_value, 7);
        push_exp(OP_SQUARE, 7, 0, 49);
`else
        chk("mem_value absent", mem_value, 0);
        chk("mem recall ignored", disp_value, 0);
        push_exp(OP_SQUARE, 0, 0, 0);
`endif
        opk(OP_SQUARE);
        check_issue();

        // Cube then chain result as A
        send_key(KEY_CLR, '0);
        dig(2);
        push_exp(OP_CUBE, 2, 0, 8);
        opk(OP_CUBE);
        check_issue();
        opk(OP_ADD);
        dig(3);
        push_exp(OP_ADD, 8, 3, 11);
        send_key(KEY_EQ, '0);
        check_issue();

        // Result out of operand range used as A -> error
        send_key(KEY_CLR, '0);
        dig(2); dig(5); dig(5); opk(OP_MUL); dig(2);
        push_exp(OP_MUL, 255, 2, 510);
        send_key(KEY_EQ, '0);
        check_issue();
        opk(OP_ADD);
        chk("out-of-range chain error", 32'(error), 1);
        chk("out-of-range no issue", 32'(alu_opcode), 32'(OP_MUL));
        send_key(KEY_CLR, '0);

        // Reset while in EXEC
        dig(1); opk(OP_ADD); dig(1);
        send_key(KEY_EQ, '0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst in exec key_ready", 32'(key_ready), 1);
        chk("rst in exec disp_valid", 32'(disp_valid), 0);
        chk("rst in exec disp_value", disp_value, 0);
        chk("rst in exec mem_value", mem_value, 0);
        chk("rst in exec alu_opcode", 32'(alu_opcode), 0);
        rst = 1'b0;
        check_no_pulse("no pulse after rst", 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_op_sequencer.md
# calc_op_sequencer

Keypad-side command sequencer that drives the calculator ALU. Accepts key tokens over a valid/ready handshake, builds decimal operands, issues opcode/operand pairs to the ALU, and captures its result for display. Owns the memory register, so the ALU never holds state. Sits between the keypad decoder and the ALU.

## Interface
- OPCODE_LENGTH, 5, ALU opcode width
- NUM_LENGTH, 9, signed ALU operand width
- RESULT_WIDTH, 32, signed ALU result, display and memory width
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- key_valid  in  1  key token present
- key_ready  out  1  sequencer can accept a token
- key_type  in  2  00 digit, 01 operator, 10 equals, 11 clear
- key_data  in  OPCODE_LENGTH  digit value 0-9 (digit) or opcode (operator); ignored otherwise
- alu_opcode  out  OPCODE_LENGTH  registered opcode to ALU
- alu_num_a  out  NUM_LENGTH  registered signed operand A
- alu_num_b  out  NUM_LENGTH  registered signed operand B
- alu_result  in  RESULT_WIDTH  ALU combinational result
- disp_value  out  RESULT_WIDTH  value shown: entry in progress or last result
- disp_valid  out  1  one-cycle pulse when a new result is captured
- mem_value  out  RESULT_WIDTH  memory register
- error  out  1  sticky error flag

## Operation
- States: ENTRY_A, ENTRY_B, EXEC, RESULT, ERROR. Reset: ENTRY_A; all outputs 0 except key_ready=1.
- Token accepted when key_valid && key_ready. key_ready=0 only in EXEC.
- Digit: acc <= acc*10 + d; acc is A in ENTRY_A/RESULT (RESULT first restarts A from 0), B in ENTRY_B. If the new value exceeds 255 (2^(NUM_LENGTH-1)-1), the digit is dropped and acc is held, no error. Digit 10-31: ignored. disp_value follows acc.
- Binary operator (00000-00011, 01011): latch opcode, go ENTRY_B with B=0. In RESULT, A <= last result; if result outside -256..255 go ERROR. A second binary operator in ENTRY_B replaces the latched opcode.
- Unary operator (00100-01010, 01100-01110) and Pi (01111): issue immediately with current A (or last result per range rule above), B=0; go EXEC.
- Equals: in ENTRY_B issue latched opcode with A,B; elsewhere ignored.
- Divide (00011) or modulo (01011) with B=0: no issue, go ERROR.
- EXEC: one cycle; capture alu_result into disp_value, pulse disp_valid, go RESULT.
- Clear: A, B, latched opcode, disp_value, error <- 0; go ENTRY_A. Memory untouched.
- ERROR: error=1; all tokens except clear accepted and ignored.
- Undefined opcodes (10000, 10011, 10101-10111, 11001-11111): accepted and ignored.
- Memory opcodes (with macro, handled locally, never sent to ALU): 10001 mem <= mem + disp_value; 10010 mem <= mem - disp_value (both wrap at RESULT_WIDTH); 10100 load mem into current acc (A or B), ERROR if outside -256..255; 11000 mem <= 0. State unchanged except 10100 from RESULT goes ENTRY_A.

## Timing
- Issuing token accepted at edge N: alu_* outputs valid after N; key_ready=0 during cycle N..N+1; result captured at edge N+1; disp_valid high for the cycle after N+1; key_ready=1 again after N+1.
- Throughput: one issuing op per 2 cycles; non-issuing tokens one per cycle.
- alu_* outputs hold last issued values until the next issue.
- rst in any state, including EXEC: return to reset values next edge, memory cleared, no disp_valid.

## Configuration
- CALC_SEQ_MEMORY_EN defined: memory register and opcodes 10001/10010/10100/11000 as above.
- Not defined: no memory register; mem_value tied 0; memory opcodes treated as undefined (ignored).

## Structure
- Package calc_pkg: opcode localparams (named per operation), key_type enum, state enum, operand-range constants.
- Sub-module dec_entry_accum: digit accumulation with overflow-drop, clear and load.

## Test plan
- Keys 1,2,+,3,4,= -> alu_opcode 00000, A=12, B=34; disp_value=46 with disp_valid one cycle after issue.
- Keys 2,5,6 -> disp_value 25 (digit 6 dropped), error 0.
- Keys 9,/,0,= -> error=1, no ALU issue; further digits ignored; clear -> error 0, disp_value 0.
- With CALC_SEQ_MEMORY_EN: 7,=-free path: 7, opcode 10001, clear, opcode 10100 -> mem_value 7, A=7; without macro same sequence -> mem_value 0, A unchanged.
- 2, op 00101 (cube) -> disp_value 8; then op 00000, 3, = -> A=8, B=3, result 11.
- rst asserted during EXEC -> next cycle state ENTRY_A, key_ready 1, disp_valid never pulses.
